hweval_mont_seq: RTL and testbench

Parametrised hardware-evaluation sequencer for the Montgomery multiplier cores. It drives a core through a start/done handshake for a programmable number of iterations and feeds each result back as the next operands. It also accumulates an XOR signature of all results and measures per-iteration and total latency, with an optional watchdog. It sits between the board-level evaluation top and any width-parametrised modular-multiplier core.

---
 rtl/hweval_mont_seq_if.sv | 30 +++
 rtl/hweval_mont_seq.sv | 183 ++++++++++++++++++
 tb/tb_hweval_mont_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hweval_mont_seq_if.sv
// Start/done handshake and operand bus between the evaluation
// sequencer (master) and a modular-multiplier core (slave).
interface hweval_mont_seq_if #(
  parameter int WIDTH = 1024
) ();
  logic             core_start;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_m;
  logic [WIDTH-1:0] core_result;
  logic             core_done;

  modport master (
    output core_start,
    output core_a,
    output core_b,
    output core_m,
    input  core_result,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_a,
    input  core_b,
    input  core_m,
    output core_result,
    output core_done
  );
endinterface

// File: rtl/hweval_mont_seq.sv
// Montgomery-core evaluation sequencer: chained iterations, XOR signature,
// latency stats. Optional per-iteration watchdog: HWEVAL_TIMEOUT_EN.
module hweval_mont_seq #(
  parameter int WIDTH   = 1024,
  parameter int ITER_W  = 16,
  parameter int CYC_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [ITER_W-1:0] iterations,
  input  logic [WIDTH-1:0]  seed_a,
  input  logic [WIDTH-1:0]  seed_b,
  input  logic [WIDTH-1:0]  modulus,
  hweval_mont_seq_if.master core,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [ITER_W-1:0] iter_count,
  output logic [CYC_W-1:0]  max_latency,
  output logic [CYC_W-1:0]  total_cycles,
  output logic [WIDTH-1:0]  signature,
  output logic              data_ok
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [WIDTH-1:0]  sig_q, sig_d;
  logic [ITER_W-1:0] tgt_q, tgt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] iter_inc;
  logic [CYC_W-1:0]  lat_q, lat_d;
  logic [CYC_W-1:0]  max_q, max_d;
  logic [CYC_W-1:0]  tot_q, tot_d;
  logic              to_q, to_d;

  function automatic logic [CYC_W-1:0] inc_c(
    input logic [CYC_W-1:0] v
  );
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  function automatic logic [ITER_W-1:0] inc_i(
    input logic [ITER_W-1:0] v
  );
    return (&v) ? v : v + ITER_W'(1);
  endfunction

  assign iter_inc = inc_i(iter_q);

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    sig_d   = sig_q;
    tgt_d   = tgt_q;
    iter_d  = iter_q;
    lat_d   = lat_q;
    max_d   = max_q;
    tot_d   = tot_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          sig_d  = '0;
          iter_d = '0;
          max_d  = '0;
          tot_d  = '0;
          lat_d  = '0;
          to_d   = 1'b0;
          tgt_d  = iterations;
          if (iterations != '0) begin
            a_d     = seed_a;
            b_d     = seed_b;
            m_d     = modulus;
            start_d = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        start_d = 1'b0;
        lat_d   = CYC_W'(1);
        tot_d   = inc_c(tot_q);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tot_d = inc_c(tot_q);
        if (core.core_done) begin
          sig_d  = sig_q ^ core.core_result;
          a_d    = b_q ^ core.core_result;
          b_d    = core.core_result;
          max_d  = (lat_q > max_q) ? lat_q : max_q;
          iter_d = iter_inc;
          if (iter_inc == tgt_q) begin
            state_d = S_DONE;
          end else begin
            start_d = 1'b1;
            state_d = S_LOAD;
          end
        end
`ifdef HWEVAL_TIMEOUT_EN
        // Abandon the iteration: not counted, signature untouched.
        else if (lat_q == CYC_W'(TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end
`endif
        else begin
          lat_d = inc_c(lat_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      a_q     <= WIDTH'(1);
      b_q     <= WIDTH'(1);
      m_q     <= '0;
      sig_q   <= '0;
      tgt_q   <= '0;
      iter_q  <= '0;
      lat_q   <= '0;
      max_q   <= '0;
      tot_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      sig_q   <= sig_d;
      tgt_q   <= tgt_d;
      iter_q  <= iter_d;
      lat_q   <= lat_d;
      max_q   <= max_d;
      tot_q   <= tot_d;
      to_q    <= to_d;
    end
  end

`ifndef HWEVAL_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign core.core_start = start_q;
  assign core.core_a     = a_q;
  assign core.core_b     = b_q;
  assign core.core_m     = m_q;

  assign busy         = (state_q == S_LOAD) || (state_q == S_WAIT);
  assign finished     = (state_q == S_DONE);
  assign timed_out    = to_q;
  assign iter_count   = iter_q;
  assign max_latency  = max_q;
  assign total_cycles = tot_q;
  assign signature    = sig_q;
  assign data_ok      = finished & ~to_q & sig_q[WIDTH-1];

endmodule

// File: tb/tb_hweval_mont_seq.sv
// Scoreboard bench for hweval_mont_seq: a behavioural core answers each
// start pulse; expected operands are queued at launch and popped per start.
module tb_hweval_mont_seq;
  localparam int W  = 32;
  localparam int IW = 16;
  localparam int CW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic [IW-1:0] iterations = '0;
  logic [W-1:0]  seed_a = '0;
  logic [W-1:0]  seed_b = '0;
  logic [W-1:0]  modulus = '0;
  logic          busy, finished, timed_out, data_ok;
  logic [IW-1:0] iter_count;
  logic [CW-1:0] max_latency, total_cycles;
  logic [W-1:0]  signature;

  int n_cmp = 0;
  int n_bad = 0;

  int           mode = 0;
  logic [W-1:0] const_val = '0;
  int           fixed_lat = 1;
  int           lat_q[$];
  logic [3*W-1:0] exp_q[$];
  int           starts = 0;

  hweval_mont_seq_if #(.WIDTH(W)) bus ();

  hweval_mont_seq #(
    .WIDTH(W), .ITER_W(IW), .CYC_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .iterations   (iterations),
    .seed_a       (seed_a),
    .seed_b       (seed_b),
    .modulus      (modulus),
    .core         (bus.master),
    .busy         (busy),
    .finished     (finished),
    .timed_out    (timed_out),
    .iter_count   (iter_count),
    .max_latency  (max_latency),
    .total_cycles (total_cycles),
    .signature    (signature),
    .data_ok      (data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: mode 0 constant result, 1 a^b, 2 never completes.
  initial begin
    int           cnt;
    logic         prev;
    logic [W-1:0] res;
    logic [3*W-1:0] e;
    cnt = 0;
    prev = 1'b0;
    res = '0;
    bus.core_done = 1'b0;
    bus.core_result = '0;
    forever begin
      @(negedge clk);
      bus.core_done = 1'b0;
      if (bus.core_start) begin
        starts++;
        check("start_width", 64'(prev), 64'(0));
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("op_a", 64'(bus.core_a), 64'(e[3*W-1:2*W]));
          check("op_b", 64'(bus.core_b), 64'(e[2*W-1:W]));
          check("op_m", 64'(bus.core_m), 64'(e[W-1:0]));
        end
        res = (mode == 0) ? const_val : (bus.core_a ^ bus.core_b);
        if (mode != 2)
          cnt = (lat_q.size() != 0) ? lat_q.pop_front() : fixed_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.core_done = 1'b1;
          bus.core_result = res;
        end
      end
      prev = bus.core_start;
    end
  end

  task automatic campaign(input int n, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] m,
                          input int bound, output int cyc,
                          output bit fin, output logic [W-1:0] esig);
    logic [W-1:0] ra, rb, r;
    ra = a;
    rb = b;
    esig = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ra, rb, m});
      r = (mode == 0) ? const_val : (ra ^ rb);
      esig ^= r;
      ra = rb ^ r;
      rb = r;
    end
    starts = 0;
    @(negedge clk);
    run = 1'b1;
    iterations = IW'(n);
    seed_a = a;
    seed_b = b;
    modulus = m;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < bound) begin
      @(negedge clk);
      run = 1'b0;
      cyc++;
      fin = finished;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int           cyc;
    bit           fin;
    logic [W-1:0] es;

    repeat (3) @(negedge clk);
    check("rst_start", 64'(bus.core_start), 64'(0));
    check("rst_a", 64'(bus.core_a), 64'(1));
    check("rst_b", 64'(bus.core_b), 64'(1));
    check("rst_m", 64'(bus.core_m), 64'(0));
    check("rst_sig", 64'(signature), 64'(0));
    check("rst_busy", 64'({busy, finished, timed_out}), 64'(0));
    check("rst_tot", 64'(total_cycles), 64'(0));
    resetn = 1'b1;

    mode = 0; const_val = 32'h5; fixed_lat = 3;
    campaign(1, 32'h1, 32'h1, 32'h7, 200, cyc, fin, es);
    check("s_fin", 64'(fin), 64'(1));
    check("s_cyc", 64'(cyc), 64'(5));
    check("s_sig", 64'(signature), 64'(5));
    check("s_iter", 64'(iter_count), 64'(1));
    check("s_max", 64'(max_latency), 64'(3));
    check("s_tot", 64'(total_cycles), 64'(4));
    check("s_busy", 64'(busy), 64'(0));
    check("s_ok", 64'(data_ok), 64'(0));
    check("s_starts", 64'(starts), 64'(1));

    const_val = 32'h8000_0000; fixed_lat = 2;
    campaign(1, 32'h2, 32'h3, 32'h9, 200, cyc, fin, es);
    check("msb_sig", 64'(signature), 64'(es));
    check("msb_tot", 64'(total_cycles), 64'(3));
    check("msb_ok", 64'(data_ok), 64'(1));

    mode = 1; fixed_lat = 2;
    campaign(3, 32'h3, 32'h5, 32'hb, 200, cyc, fin, es);
    check("c_fin", 64'(fin), 64'(1));
    check("c_sig", 64'(signature), 64'(5));
    check("c_tot", 64'(total_cycles), 64'(9));
    check("c_cyc", 64'(cyc), 64'(10));
    check("c_iter", 64'(iter_count), 64'(3));
    check("c_max", 64'(max_latency), 64'(2));
    check("c_starts", 64'(starts), 64'(3));
    check("c_ok", 64'(data_ok), 64'(0));

    campaign(0, 32'h3, 32'h5, 32'hb, 200, cyc, fin, es);
    check("z_cyc", 64'(cyc), 64'(1));
    check("z_fin", 64'(finished), 64'(1));
    check("z_stats", 64'({iter_count, max_latency}), 64'(0));
    check("z_tot", 64'(total_cycles), 64'(0));
    check("z_sig", 64'(signature), 64'(0));
    repeat (3) @(negedge clk);
    check("z_starts", 64'(starts), 64'(0));

    lat_q = '{1, 7, 4};
    fork
      campaign(3, 32'h11, 32'h22, 32'h5, 200, cyc, fin, es);
      begin
        repeat (6) @(negedge clk);
        check("v_busy_at_rerun", 64'(busy), 64'(1));
        run = 1'b1;
        iterations = 9;
        seed_a = 32'hff;
        @(negedge clk);
        run = 1'b0;
      end
    join
    check("v_fin", 64'(fin), 64'(1));
    check("v_max", 64'(max_latency), 64'(7));
    check("v_tot", 64'(total_cycles), 64'(15));
    check("v_cyc", 64'(cyc), 64'(16));
    check("v_iter", 64'(iter_count), 64'(3));
    check("v_sig", 64'(signature), 64'(es));
    check("v_starts", 64'(starts), 64'(3));

    mode = 2;
`ifdef HWEVAL_TIMEOUT_EN
    campaign(1, 32'h1, 32'h2, 32'h3, 200, cyc, fin, es);
    check("w_fin", 64'(fin), 64'(1));
    check("w_to", 64'(timed_out), 64'(1));
    check("w_iter", 64'(iter_count), 64'(0));
    check("w_tot", 64'(total_cycles), 64'(17));
    check("w_sig", 64'(signature), 64'(0));
    check("w_ok", 64'(data_ok), 64'(0));
`else
    campaign(1, 32'h1, 32'h2, 32'h3, 1000, cyc, fin, es);
    check("w_fin", 64'(fin), 64'(0));
    check("w_busy", 64'(busy), 64'(1));
    check("w_to", 64'(timed_out), 64'(0));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("w_rst_busy", 64'(busy), 64'(0));
`endif
    exp_q.delete();

    mode = 0; const_val = 32'h8000_0009; fixed_lat = 10;
    campaign(1, 32'h4, 32'h6, 32'h3, 4, cyc, fin, es);
    check("r_inwait", 64'(busy), 64'(1));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("r_busy", 64'({busy, finished, timed_out}), 64'(0));
    check("r_a", 64'(bus.core_a), 64'(1));
    check("r_b", 64'(bus.core_b), 64'(1));
    check("r_m", 64'(bus.core_m), 64'(0));
    check("r_start", 64'(bus.core_start), 64'(0));
    check("r_tot", 64'(total_cycles), 64'(0));
    check("r_iter", 64'({iter_count, max_latency}), 64'(0));
    repeat (15) @(negedge clk);
    check("r_late_sig", 64'(signature), 64'(0));
    check("r_late_iter", 64'(iter_count), 64'(0));
    check("r_late_state", 64'({busy, finished}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
